// File: rtl/mult_seq.sv
// Sequential shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH, optional two's-complement mode.
// Latency 2n+p+2 cycles from init sample to done; no backpressure, init only accepted in IDLE.
module mult_seq #(
    parameter int WIDTH      = 16,
    parameter int DONE_HOLD  = 30,
    parameter int EARLY_EXIT = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               init,
    input  logic               is_signed,
    input  logic [WIDTH-1:0]   op_A,
    input  logic [WIDTH-1:0]   op_B,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int HW = $clog2(DONE_HOLD + 1);
    localparam logic [CW-1:0] BITS_LAST = CW'(WIDTH);
    localparam logic [HW-1:0] HOLD_LAST = HW'(DONE_HOLD - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_CHECK = 3'd2,
        S_ADD   = 3'd3,
        S_SHIFT = 3'd4,
        S_FIX   = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t               state_q, state_d;
    logic [2*WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic                 neg_q, neg_d;
    logic                 sgn_q, sgn_d;
    logic [CW-1:0]        bitcnt_q, bitcnt_d;
    logic [HW-1:0]        hold_q, hold_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [2*WIDTH-1:0]   result_q, result_d;

    logic [WIDTH-1:0]     mag_a, mag_b, b_shift;
    logic [CW-1:0]        bitcnt_inc;

    // The magnitude of the most negative value still fits as an unsigned WIDTH-bit number.
    assign mag_a      = (sgn_q && op_A[WIDTH-1]) ? -op_A : op_A;
    assign mag_b      = (sgn_q && op_B[WIDTH-1]) ? -op_B : op_B;
    assign b_shift    = b_q >> 1;
    assign bitcnt_inc = bitcnt_q + CW'(1);

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        neg_d    = neg_q;
        sgn_d    = sgn_q;
        bitcnt_d = bitcnt_q;
        hold_d   = hold_q;
        busy_d   = busy_q;
        done_d   = done_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (init) begin
                    sgn_d   = is_signed;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                a_d      = {{WIDTH{1'b0}}, mag_a};
                b_d      = mag_b;
                neg_d    = sgn_q & (op_A[WIDTH-1] ^ op_B[WIDTH-1]);
                result_d = '0;
                bitcnt_d = '0;
                busy_d   = 1'b1;
                state_d  = S_CHECK;
            end
            S_CHECK: begin
                state_d = b_q[0] ? S_ADD : S_SHIFT;
            end
            S_ADD: begin
                result_d = result_q + a_q;
                state_d  = S_SHIFT;
            end
            S_SHIFT: begin
                a_d      = a_q << 1;
                b_d      = b_shift;
                bitcnt_d = bitcnt_inc;
                if (((EARLY_EXIT != 0) && (b_shift == '0)) || (bitcnt_inc == BITS_LAST))
                    state_d = S_FIX;
                else
                    state_d = S_CHECK;
            end
            S_FIX: begin
                // Negating a zero product yields zero, so no special case is needed.
                if (neg_q)
                    result_d = -result_q;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                hold_d  = '0;
                state_d = S_DONE;
            end
            S_DONE: begin
                hold_d = hold_q + HW'(1);
                if (hold_q == HOLD_LAST) begin
                    done_d  = 1'b0;
                    hold_d  = '0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            neg_q    <= 1'b0;
            sgn_q    <= 1'b0;
            bitcnt_q <= '0;
            hold_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            neg_q    <= neg_d;
            sgn_q    <= sgn_d;
            bitcnt_q <= bitcnt_d;
            hold_q   <= hold_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: doc/mult_seq.md
Name: mult_seq

Overview:
- Parametrised sequential shift-add multiplier for the femtoRV coprocessor path.
- Successor to the fixed 16-bit unsigned multiplier core.
- Adds WIDTH generalisation, a per-operation signed/unsigned mode, a busy flag, configurable done-hold length and optional early termination.
- Started by an init strobe from the bus glue; the result is held stable for software readback.

Parameters:
- WIDTH, 16, operand width in bits (range 2..32); result is 2*WIDTH.
- DONE_HOLD, 30, number of clock cycles done stays high (minimum 1).
- EARLY_EXIT, 1, 1 = finish when the remaining multiplier is zero; 0 = always process WIDTH bits.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- init  input  1  start request, sampled only in IDLE.
- is_signed  input  1  1 = two's-complement operands; sampled in IDLE together with init.
- op_A  input  WIDTH  multiplicand, captured in LOAD.
- op_B  input  WIDTH  multiplier, captured in LOAD.
- busy  output  1  high from LOAD through FIX.
- done  output  1  high for DONE_HOLD cycles once the result is valid.
- result  output  2*WIDTH  product; holds until the next LOAD.

Behaviour:
- Reset (reset=0, async): state=IDLE; done=0, busy=0, result=0; internal A, B, neg, bit counter and hold counter = 0.
- All outputs are registered.
- IDLE: if init=1, latch is_signed and go to LOAD; otherwise stay.
- LOAD:
  - A (2*WIDTH) = zero-extended magnitude of op_A; B (WIDTH) = magnitude of op_B.
  - In signed mode, magnitude = two's-complement negation when the MSB is 1.
  - Unsigned mode takes the operands raw.
  - neg = is_signed & (op_A[MSB] ^ op_B[MSB]).
  - result=0, bitcnt=0, busy=1 → CHECK.
- CHECK: B[0]=1 → ADD, else → SHIFT.
- ADD: result = result + A (2*WIDTH, no overflow possible) → SHIFT.
- SHIFT: A <<= 1, B >>= 1, bitcnt++. Go to FIX when either condition holds, else → CHECK:
  - the new B == 0 and EARLY_EXIT=1;
  - bitcnt reaches WIDTH.
- FIX: if neg, result = -result (2*WIDTH two's complement); busy=0 → DONE.
- DONE:
  - done=1 and the hold counter increments each cycle.
  - After exactly DONE_HOLD cycles with done=1, done=0 and state → IDLE.
  - init is ignored while in DONE.
- Illegal state encoding → IDLE.
- Latency, with EARLY_EXIT=1 and the init-sampling edge counted as edge 0:
  - done rises after edge 2*n + p + 2.
  - n = index of the highest set bit of |op_B| + 1 (n=1 when op_B=0).
  - p = popcount(|op_B|).
  - With EARLY_EXIT=0, n = WIDTH.
- Boundaries:
  - op_B=0: one CHECK/SHIFT pass, result=0.
  - op_A=0: result=0, normal timing.
  - Signed minimum value −2^(WIDTH−1): its magnitude 2^(WIDTH−1) fits unsigned in WIDTH bits. (−2^(W−1))² = 2^(2W−2) is representable.
  - A zero product with neg=1 must give 0, not −0 garbage.
- init held high continuously: one operation per IDLE visit; a new operation starts on the first IDLE cycle after DONE.
- Reset asserted mid-operation: immediate abort to the reset values; no done pulse is produced.

Test Plan:
- WIDTH=16, unsigned, op_A=3, op_B=5, init 1 cycle → result=15, done rises after edge 10, stays high 30 cycles, busy low when done rises.
- Signed, op_A=−7 (0xFFF9), op_B=6 → result=0xFFFFFFD6 (−42); signed op_A=−32768, op_B=−32768 → result=0x40000000.
- Unsigned, op_A=0xFFFF, op_B=0xFFFF → result=0xFFFE0001, done after edge 2*16+16+2=50; op_B=0 → result=0, done after edge 4.
- EARLY_EXIT=0, op_B=1 → done after edge 2*16+1+2=35; WIDTH=8, DONE_HOLD=1, signed −1×−1 → result=16'h0001, done high exactly 1 cycle.
- init held high for 100 cycles → back-to-back operations, each with a full DONE_HOLD pulse, result cleared at each LOAD.
- reset pulled low in the cycle after ADD → result=0, done=0, busy=0 asynchronously; after release, the next init gives correct results.
